// File: rtl/pci_edu_pkg.sv
// Shared constants and byte-enable helpers for the PCI EDU BAR0 register block.
package pci_edu_pkg;

    localparam logic [5:0] IdxId        = 6'd0;
    localparam logic [5:0] IdxLive      = 6'd1;
    localparam logic [5:0] IdxFact      = 6'd2;
    localparam logic [5:0] IdxStatus    = 6'd8;
    localparam logic [5:0] IdxIrqStatus = 6'd9;
    localparam logic [5:0] IdxIrqRaise  = 6'd24;
    localparam logic [5:0] IdxIrqAck    = 6'd25;

    localparam logic [31:0] EduId = 32'h010000ED;

    localparam int unsigned StatusBusyBit  = 0;
    localparam int unsigned StatusIrqEnBit = 7;

    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] m;
        m = byte_mask(be);
        return (old_val & ~m) | (new_val & m);
    endfunction

endpackage

// File: rtl/pci_edu_fact.sv
// Iterative factorial engine: one multiply per busy cycle, result kept modulo 2^32.
module pci_edu_fact (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] start_val,
    output logic        busy,
    output logic [31:0] operand,
    output logic [31:0] result,
    output logic        done
);
    logic [31:0] acc_q;
    logic [31:0] cnt_q;

    // Pulses in the last busy cycle, i.e. on the edge where busy falls.
    assign done = busy && (cnt_q <= 32'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy    <= 1'b0;
            operand <= '0;
            result  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (busy) begin
            if (cnt_q <= 32'd1) begin
                result <= acc_q;
                busy   <= 1'b0;
            end else begin
                acc_q <= acc_q * cnt_q;
                cnt_q <= cnt_q - 32'd1;
            end
        end else if (start) begin
            operand <= start_val;
            acc_q   <= 32'd1;
            cnt_q   <= start_val;
            busy    <= 1'b1;
        end
    end

endmodule

// File: rtl/pci_edu_regs.sv
// BAR0 register block of the PCI EDU function: ID, LIVE, FACT, STATUS and interrupt registers.
module pci_edu_regs
    import pci_edu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_enable,
    input  logic        mem_iswrite,
    input  logic [5:0]  mem_offset,
    input  logic [3:0]  mem_byte_en,
    input  logic [31:0] mem_write_val,
    output logic [31:0] mem_read_val,
    input  logic        intx_disable,
    output logic        irq
);
    logic        rd_strobe;
    logic        wr_strobe;
    logic [31:0] wr_data_masked;
    logic        fact_start;
    logic [31:0] fact_start_val;
    logic        fact_busy;
    logic        fact_done;
    logic [31:0] fact_operand;
    logic [31:0] fact_result;
    logic [31:0] live_q;
    logic        irq_en_q;
    logic [31:0] irq_status_q;
    logic [31:0] irq_status_d;
    logic [31:0] read_data;

    assign rd_strobe      = mem_enable && !mem_iswrite;
    assign wr_strobe      = mem_enable && mem_iswrite;
    assign wr_data_masked = mem_write_val & byte_mask(mem_byte_en);
    assign fact_start     = wr_strobe && (mem_offset == IdxFact) && !fact_busy;
    assign fact_start_val = merge_bytes(fact_operand, mem_write_val, mem_byte_en);

    pci_edu_fact u_fact (
        .clk       (clk),
        .rst       (rst),
        .start     (fact_start),
        .start_val (fact_start_val),
        .busy      (fact_busy),
        .operand   (fact_operand),
        .result    (fact_result),
        .done      (fact_done)
    );

    // ACK clears first so a completion in the same cycle still sets bit 0.
    always_comb begin
        irq_status_d = irq_status_q;
        if (wr_strobe && (mem_offset == IdxIrqAck)) begin
            irq_status_d = irq_status_d & ~wr_data_masked;
        end
        if (wr_strobe && (mem_offset == IdxIrqRaise)) begin
            irq_status_d = irq_status_d | wr_data_masked;
        end
        if (fact_done && irq_en_q) begin
            irq_status_d[0] = 1'b1;
        end
    end

    always_comb begin
        read_data = '0;
        case (mem_offset)
            IdxId:        read_data = EduId;
            IdxLive:      read_data = ~live_q;
            IdxFact:      read_data = fact_busy ? fact_operand : fact_result;
            IdxStatus: begin
                read_data[StatusBusyBit]  = fact_busy;
                read_data[StatusIrqEnBit] = irq_en_q;
            end
            IdxIrqStatus: read_data = irq_status_q;
            default:      read_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_read_val <= '0;
            live_q       <= '0;
            irq_en_q     <= 1'b0;
            irq_status_q <= '0;
            irq          <= 1'b0;
        end else begin
            if (rd_strobe) begin
                mem_read_val <= read_data;
            end
            if (wr_strobe && (mem_offset == IdxLive)) begin
                live_q <= merge_bytes(live_q, mem_write_val, mem_byte_en);
            end
            if (wr_strobe && (mem_offset == IdxStatus) && mem_byte_en[0]) begin
                irq_en_q <= mem_write_val[StatusIrqEnBit];
            end
            irq_status_q <= irq_status_d;
            irq          <= (irq_status_q != '0) && !intx_disable;
        end
    end

endmodule
